// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward decisions plus memory-wait FSM and stall counters.
// Optional macro FORWARDING_EN enables E-stage operand forwarding (otherwise stall on any RAW).
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr_d_i,
  input  logic [4:0]  rs2_addr_d_i,
  input  logic [4:0]  rs1_addr_e_i,
  input  logic [4:0]  rs2_addr_e_i,
  input  logic [4:0]  rd_addr_e_i,
  input  logic        reg_write_e_i,
  input  logic [1:0]  result_src_e_i,
  input  logic [4:0]  rd_addr_m_i,
  input  logic        reg_write_m_i,
  input  logic [4:0]  rd_addr_w_i,
  input  logic        reg_write_w_i,
  input  logic        pc_src_e_i,
  input  logic        dmem_req_m_i,
  input  logic        dmem_ready_i,
  output logic        stall_f_o,
  output logic        stall_d_o,
  output logic        stall_e_o,
  output logic        stall_m_o,
  output logic        flush_d_o,
  output logic        flush_e_o,
  output logic [1:0]  forward_a_e_o,
  output logic [1:0]  forward_b_e_o,
  output logic [1:0]  state_o,
  output logic        timeout_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0] StRun     = 2'b00;
  localparam logic [1:0] StMemWait = 2'b01;

  logic        mem_wait;
  logic        hit_e;
  logic        data_hazard;
  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign mem_wait = dmem_req_m_i & ~dmem_ready_i;

  // x0 is excluded from every match so it never stalls or forwards.
  assign hit_e = reg_write_e_i && (rd_addr_e_i != 5'd0) &&
                 ((rd_addr_e_i == rs1_addr_d_i) || (rd_addr_e_i == rs2_addr_d_i));

`ifdef FORWARDING_EN
  assign data_hazard = hit_e && (result_src_e_i == 2'b01);

  always_comb begin
    forward_a_e_o = 2'b00;
    if (reg_write_m_i && (rd_addr_m_i != 5'd0) && (rd_addr_m_i == rs1_addr_e_i)) begin
      forward_a_e_o = 2'b10;
    end else if (reg_write_w_i && (rd_addr_w_i != 5'd0) && (rd_addr_w_i == rs1_addr_e_i)) begin
      forward_a_e_o = 2'b01;
    end
  end

  always_comb begin
    forward_b_e_o = 2'b00;
    if (reg_write_m_i && (rd_addr_m_i != 5'd0) && (rd_addr_m_i == rs2_addr_e_i)) begin
      forward_b_e_o = 2'b10;
    end else if (reg_write_w_i && (rd_addr_w_i != 5'd0) && (rd_addr_w_i == rs2_addr_e_i)) begin
      forward_b_e_o = 2'b01;
    end
  end
`else
  logic hit_m;
  logic hit_w;
  logic unused_fwd_inputs;

  assign hit_m = reg_write_m_i && (rd_addr_m_i != 5'd0) &&
                 ((rd_addr_m_i == rs1_addr_d_i) || (rd_addr_m_i == rs2_addr_d_i));
  assign hit_w = reg_write_w_i && (rd_addr_w_i != 5'd0) &&
                 ((rd_addr_w_i == rs1_addr_d_i) || (rd_addr_w_i == rs2_addr_d_i));

  // Without forwarding every in-flight writer is a hazard until it retires.
  assign data_hazard = hit_e | hit_m | hit_w;

  assign forward_a_e_o = 2'b00;
  assign forward_b_e_o = 2'b00;

  assign unused_fwd_inputs = ^{rs1_addr_e_i, rs2_addr_e_i, result_src_e_i};
`endif

  // Priority: memory wait > redirect > data hazard.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    if (mem_wait) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
    end else if (pc_src_e_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (data_hazard) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      StRun: begin
        if (mem_wait) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd0;
        end
      end
      StMemWait: begin
        if (!mem_wait) begin
          state_d = StRun;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = StRun;
    endcase

    if (wait_cnt_d == 8'hFF) begin
      timeout_d = 1'b1;
    end

    if (stall_f_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
